dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, byte-addressed data memory for the RISC-V core, replacing the word-indexed data memory. Supports the RV32I load/store widths LB/LH/LW/LBU/LHU/SB/SH/SW, with sign/zero extension, byte-lane writes and misalignment/range error detection. Uses a valid/ready request port, a registered 1-cycle read response, and an optional post-reset clear sweep. Sits between the execute stage's address/store-data outputs and the writeback mux.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥ 4.
- CLEAR_ON_RESET, 1: 1 = sweep every word to zero after reset; 0 = contents retained across reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, out-of-range or illegal funct3.
- busy  out  1  clear sweep in progress.

## Operation
- States: CLEAR, IDLE. Reset with CLEAR_ON_RESET=1 → CLEAR, clr_idx=0; reset with CLEAR_ON_RESET=0 → IDLE.
- CLEAR: each cycle writes 0 to word clr_idx and increments it. After writing word DEPTH_WORDS-1 → IDLE. req_ready=0, busy=1.
- IDLE: req_ready=1, busy=0. One request is accepted per cycle; responses have no backpressure.
- Word index = req_addr[IDX_W+1:2], where IDX_W = log2(DEPTH_WORDS). Out-of-range when any req_addr[31:IDX_W+2] bit is set.
- Misaligned: H accesses with addr[0]=1; W accesses with addr[1:0]≠0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000/001/010.
- Store, no error: writes only the addressed lanes.
  - SB writes byte addr[1:0].
  - SH writes bytes {addr[1],0} and {addr[1],1}.
  - SW writes all four bytes.
  - Little-endian.
- Load, no error:
  - Select the byte or halfword by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Error: no memory write; rsp_rdata=0, rsp_err=1.
- Reset mid-operation: an in-flight response is dropped (rsp_valid=0 after the reset edge). A store accepted at the same edge where reset is high is NOT performed.

## Timing
- Reset values: req_ready = (CLEAR_ON_RESET ? 0 : 1), busy = CLEAR_ON_RESET, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Clear sweep: the first write occurs at the first edge with reset low. req_ready rises exactly DEPTH_WORDS cycles after reset deasserts.
- Store: memory updated at the accepting edge; rsp_valid is high for the following cycle.
- Load: rsp_valid/rsp_rdata/rsp_err registered, valid the cycle after acceptance (latency 1). The read uses memory state before that edge.
- Back-to-back store then load to the same address on consecutive cycles returns the new data. No forwarding is needed because the write lands at the store's accept edge.
- rsp_valid is low in any cycle not following an accept.

## Structure
- Package dmem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum {CLEAR, IDLE}.
  - Function log2 for IDX_W.
- Sub-module dmem_align is combinational and holds:
  - Store lane-mask and data-replication generation.
  - Load byte/halfword extraction and extension.
  - Misalign/illegal detection.
- Top level holds the FSM, clear counter, memory array with per-byte writes, and response registers.

## Test plan
- Reset with DEPTH_WORDS=64, CLEAR_ON_RESET=1 → busy=1 and req_ready=0 for 64 cycles after reset falls, then req_ready=1; LW 0x00 and LW 0xFC return 0.
- SW 0x10 ← 0x8070_F0A5, then LB 0x10 → 0xFFFF_FFA5; LBU 0x13 → 0x0000_0080; LH 0x12 → 0xFFFF_8070; LHU 0x10 → 0x0000_F0A5; each response is 1 cycle after accept.
- SB 0x21 ← 0x0000_00CC over word 0x1122_3344 → LW 0x20 = 0x1122_CC44; SH 0x22 ← 0xBEEF → LW 0x20 = 0xBEEF_CC44.
- LW 0x11, SH 0x13, LW 0x100 (depth 64), store funct3=100 → rsp_err=1 and rsp_rdata=0 for each; memory unchanged, verified by a follow-up LW.
- Back-to-back: SW 0x30 ← 0xDEAD_BEEF then LW 0x30 on the next cycle → 0xDEAD_BEEF; continuous requests for 10 cycles → 10 rsp_valid pulses.
- Reset asserted while a load is in flight and a store is being accepted → no rsp_valid, store not written, clear sweep restarts; with CLEAR_ON_RESET=0, prior data survives reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, FSM states and sizing helper for the data memory
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {CLEAR, IDLE} state_t;

   function automatic int log2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: lane masks, store replication, load extraction/extension and alignment checks
module dmem_align
   import dmem_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_mask,
   output logic [31:0] o_wword,
   output logic [31:0] o_rdata,
   output logic        o_err
);
   logic        w_h, w_w, w_sx, w_illegal;
   logic [15:0] w_sh;
   assign w_h = i_funct3[1:0] == F3_H[1:0];
   assign w_w = i_funct3[1:0] == F3_W[1:0];
   assign w_sx = ~i_funct3[2];
   // loads allow the unsigned B/H forms; stores have no unsigned variants
   assign w_illegal = (i_funct3[1:0] == 2'b11) | (i_we ? i_funct3[2] : i_funct3 == 3'b110);
   assign o_err = w_illegal | (w_h & i_addr[0]) | (w_w & |i_addr);
   assign o_mask = w_w ? 4'b1111 : w_h ? {{2{i_addr[1]}}, {2{~i_addr[1]}}} : 4'b0001 << i_addr;
   assign o_wword = w_w ? i_wdata : w_h ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
   assign w_sh = 16'(i_rword >> {i_addr, 3'b000});
   assign o_rdata = w_w ? i_rword
                  : w_h ? {{16{w_sx & w_sh[15]}}, w_sh}
                  : {{24{w_sx & w_sh[7]}}, w_sh[7:0]};
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32I data memory with valid/ready requests and a registered response
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS    = 64,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);
   localparam int IDX_W = log2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH_WORDS - 1);

   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_clr_idx, w_idx;
   logic [31:0]        r_mem [DEPTH_WORDS];
   logic [31:0]        w_rword, w_wword, w_rdata;
   logic [3:0]         w_mask;
   logic               w_align_err, w_err, w_acc;

   assign w_idx = req_addr[IDX_W+1:2];
   assign w_rword = r_mem[w_idx];
   assign w_err = w_align_err | (|req_addr[31:IDX_W+2]);
   assign req_ready = r_state == IDLE;
   assign busy = r_state == CLEAR;
   assign w_acc = req_valid & req_ready;

   dmem_align u_align (
      .i_we     (req_we),
      .i_funct3 (req_funct3),
      .i_addr   (req_addr[1:0]),
      .i_wdata  (req_wdata),
      .i_rword  (w_rword),
      .o_mask   (w_mask),
      .o_wword  (w_wword),
      .o_rdata  (w_rdata),
      .o_err    (w_align_err)
   );

   always_comb begin
      w_next = r_state;
      if (r_state == CLEAR && r_clr_idx == LAST) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_next;
         r_clr_idx <= busy ? r_clr_idx + 1'b1 : '0;
      end
   end

   // a request presented while reset is high is discarded, so writes are gated by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) r_mem[r_clr_idx] <= '0;
         else if (w_acc && req_we && !w_err)
            for (int b = 0; b < 4; b++)
               if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= w_acc;
         rsp_err   <= w_acc & w_err;
         rsp_rdata <= (w_acc && !req_we && !w_err) ? w_rdata : '0;
      end
   end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench; instance a clears on reset, instance b retains contents
module tb_dmem_lsu;
   import dmem_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
   logic [31:0] b_rsp_rdata;

   typedef struct {string t; logic [31:0] d; logic e; int c;} exp_t;
   exp_t sb[$];
   exp_t m_e;
   int cyc = 0, n_chk = 0, n_pass = 0, n_pulse = 0;

   dmem_lsu #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(1)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

   dmem_lsu #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(0)) u_dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rsp_valid) begin
         n_pulse++;
         if (sb.size() == 0) check("spurious_rsp", rsp_valid, 0);
         else begin
            m_e = sb.pop_front();
            check({m_e.t, "_rdata"}, rsp_rdata, m_e.d);
            check({m_e.t, "_err"}, rsp_err, 32'(m_e.e));
            check({m_e.t, "_latency"}, cyc - m_e.c, 1);
         end
      end
   end

   task automatic req(input string t, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      sb.push_back('{t, exp_d, exp_e, cyc});
      @(posedge clk); #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_clear(input string t);
      int n = 0;
      @(negedge clk);
      check({t, "_busy"}, busy, 1);
      while (!req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({t, "_cycles"}, n, 64);
      check({t, "_busy_done"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 1);
      check("rst_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_b_ready", b_req_ready, 1);
      check("rst_b_busy", b_busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_clear("clear1");
      @(posedge clk); #1;

      req("lw00", 0, F3_W, 32'h00, 0, 32'h0, 0);
      req("lwfc", 0, F3_W, 32'hFC, 0, 32'h0, 0);
      req("sw10", 1, F3_W, 32'h10, 32'h8070_F0A5, 32'h0, 0);
      req("lb10", 0, F3_B, 32'h10, 0, 32'hFFFF_FFA5, 0);
      req("lbu13", 0, F3_BU, 32'h13, 0, 32'h0000_0080, 0);
      req("lh12", 0, F3_H, 32'h12, 0, 32'hFFFF_8070, 0);
      req("lhu10", 0, F3_HU, 32'h10, 0, 32'h0000_F0A5, 0);
      req("lbu11", 0, F3_BU, 32'h11, 0, 32'h0000_00F0, 0);
      idle();

      req("sw20", 1, F3_W, 32'h20, 32'h1122_3344, 32'h0, 0);
      req("sb21", 1, F3_B, 32'h21, 32'h0000_00CC, 32'h0, 0);
      req("lw20a", 0, F3_W, 32'h20, 0, 32'h1122_CC44, 0);
      req("sh22", 1, F3_H, 32'h22, 32'h0000_BEEF, 32'h0, 0);
      req("lw20b", 0, F3_W, 32'h20, 0, 32'hBEEF_CC44, 0);
      idle();

      req("lw11_mis", 0, F3_W, 32'h11, 0, 32'h0, 1);
      req("sh13_mis", 1, F3_H, 32'h13, 32'h0000_1234, 32'h0, 1);
      req("lw100_oor", 0, F3_W, 32'h100, 0, 32'h0, 1);
      req("sw100_oor", 1, F3_W, 32'h100, 32'hFFFF_FFFF, 32'h0, 1);
      req("sf3_100", 1, F3_BU, 32'h20, 32'hFFFF_FFFF, 32'h0, 1);
      req("lf3_011", 0, 3'b011, 32'h20, 0, 32'h0, 1);
      req("lf3_110", 0, 3'b110, 32'h20, 0, 32'h0, 1);
      req("lh11_mis", 0, F3_H, 32'h11, 0, 32'h0, 1);
      req("lw10_keep", 0, F3_W, 32'h10, 0, 32'h8070_F0A5, 0);
      req("lw20_keep", 0, F3_W, 32'h20, 0, 32'hBEEF_CC44, 0);
      req("lw00_keep", 0, F3_W, 32'h00, 0, 32'h0, 0);
      idle();

      req("sw30", 1, F3_W, 32'h30, 32'hDEAD_BEEF, 32'h0, 0);
      req("lw30", 0, F3_W, 32'h30, 0, 32'hDEAD_BEEF, 0);
      idle();
      @(negedge clk);
      n_pulse = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         req("burst_sw", 1, F3_W, 32'h80 + 4*i, 32'hA500_0000 | i, 32'h0, 0);
         req("burst_lw", 0, F3_W, 32'h80 + 4*i, 0, 32'hA500_0000 | i, 0);
      end
      idle();
      repeat (2) @(negedge clk);
      check("burst_pulses", n_pulse, 10);

      req("sw40", 1, F3_W, 32'h40, 32'h0BAD_F00D, 32'h0, 0);
      idle();
      reset = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40;
      @(posedge clk); #1;
      req_we = 1'b1; req_wdata = 32'h1234_5678;
      @(negedge clk);
      check("rst_drop_a", rsp_valid, 0);
      check("rst_drop_b", b_rsp_valid, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b0;
      wait_clear("clear2");
      @(posedge clk); #1;
      req("lw40_cleared", 0, F3_W, 32'h40, 0, 32'h0, 0);
      @(negedge clk);
      check("keep_b_valid", b_rsp_valid, 1);
      check("keep_b_data", b_rsp_rdata, 32'h0BAD_F00D);
      check("keep_b_err", b_rsp_err, 0);
      idle();
      repeat (2) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
